fifo_read_arbiter: RTL and testbench
====================================

# fifo_read_arbiter

Round-robin arbiter sharing the read port of the asynchronous FIFO's read-clock domain among NUM_REQ consumers. Grants one consumer at a time for a burst of up to BURST_LEN words and drives the FIFO read enable from the granted consumer's request and the FIFO empty flag. Returns each popped word, registered and tagged with the consumer index. Sits in the read-clock domain between the FIFO read side and the consumers.

## Interface
- NUM_REQ, 4, number of requesting consumers (2..8)
- BURST_LEN, 4, maximum words popped per grant (1..16)
- DATA_WIDTH, 8, FIFO word width
- ID_W, $clog2(NUM_REQ), width of consumer index
- clk  in  1  read-domain clock (same clock as the FIFO read side); one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-consumer read request, level-sensitive
- r_empty  in  1  FIFO empty flag
- r_data  in  DATA_WIDTH  FIFO head word, valid combinationally whenever r_empty=0 (first-word-fall-through)
- r_en  out  1  FIFO pop, combinational
- gnt  out  NUM_REQ  one-hot grant, registered; all-zero when idle
- out_valid  out  1  registered, one word delivered
- out_data  out  DATA_WIDTH  registered delivered word
- out_id  out  ID_W  registered index of consumer owning out_data
- busy  out  1  registered, high in BURST

## Operation
- States: IDLE, BURST. Internal: sel (ID_W), last (ID_W), cnt ($clog2(BURST_LEN)+1 bits).
- IDLE: gnt=0, r_en=0. If any req bit high and r_empty=0: pick the first set req index scanning last+1, last+2, … mod NUM_REQ. Next edge: state=BURST, sel=pick, gnt=onehot(pick), cnt=0, last=pick. Otherwise stay IDLE.
- BURST: r_en = req[sel] & ~r_empty. Each edge with r_en=1: cnt+1; out_valid=1, out_data=r_data, out_id=sel. Edges without a pop: out_valid=0.
- BURST exit to IDLE (gnt cleared next edge) when either:
  - pop with cnt==BURST_LEN-1 (burst complete); or
  - req[sel]=0 (no pop that cycle).
- r_empty=1 while req[sel]=1: hold grant, no pop, cnt unchanged. No timeout.
- Requests from non-granted consumers are ignored until IDLE. Changes to non-granted req bits never affect r_en.
- Fairness: last is updated at grant. A consumer continuously requesting is served within NUM_REQ grants.
- Reset: state=IDLE, gnt=0, busy=0, sel=0, cnt=0, last=NUM_REQ-1 (consumer 0 wins the first arbitration), out_valid=0, out_data=0, out_id=0.
- Reset mid-burst: r_en drops in the reset cycle (state forced IDLE on that edge; r_en is gated by rst=1 combinationally). Word in flight is discarded; out_valid=0 after the edge.
- Invariants: gnt one-hot or zero; r_en=1 only when busy=1, r_empty=0 and req[sel]=1; never pops when r_empty=1.

## Timing
- Arbitration: req seen at edge N in IDLE → gnt/busy at N+1 → first r_en in cycle N+1 → out_valid at N+2.
- Throughput within a burst: one word per clock while req[sel]=1 and r_empty=0.
- Every burst end costs one IDLE cycle before the next grant. Peak rate is BURST_LEN words per BURST_LEN+1 cycles.
- Data latency: r_data sampled on the popping edge; out_data/out_id/out_valid valid one cycle after r_en.
- r_empty is registered in the FIFO. The arbiter takes it as-is and adds no extra lookahead.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111, FIFO holding 3 words → gnt=0, r_en=0, out_valid=0, out_data=0 throughout; after release consumer 0 is granted first.
- Single consumer: req=4'b0100, FIFO holds words 0xA0..0xA5, BURST_LEN=4 → 0xA0..0xA3 out with out_id=2 on 4 consecutive cycles; then 1 idle cycle; regrant to 2; 0xA4, 0xA5 out; then hold with r_en=0 while empty.
- Round-robin: req=4'b1111, FIFO never empty → grant order 0,1,2,3,0; each burst exactly 4 words; out_id sequence matches.
- Early release: consumer 1 granted, req[1] dropped after 2 pops → exactly 2 words with out_id=1; IDLE next cycle; next grant to lowest set index after 1.
- Empty mid-burst: consumer 3 granted, FIFO empties after 1 pop, refilled 5 cycles later → r_en=0 and grant held for 5 cycles; burst resumes; total 4 words then release.
- Reset mid-burst: assert rst during the 3rd pop → r_en=0 that cycle; after the edge, state IDLE and out_valid=0; FIFO read count advanced by 2 only.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//
// Round-robin arbiter that shares the read port of a first-word-fall-through
// FIFO (read-clock domain) among NUM_REQ consumers. A winner is granted for a
// burst of up to BURST_LEN pops. The FIFO pop is driven combinationally from
// the granted consumer's request and the empty flag. Each popped word is
// returned one cycle later, registered and tagged with the consumer index.
//
// Ports
//   clk        read-domain clock, all state on the rising edge
//   rst        synchronous active-high reset
//   req        per-consumer level-sensitive read request
//   r_empty    FIFO empty flag
//   r_data     FIFO head word (valid whenever r_empty=0)
//   r_en       FIFO pop (combinational)
//   gnt        one-hot registered grant, zero when idle
//   out_valid  registered: one word delivered this cycle
//   out_data   registered delivered word
//   out_id     registered index of the consumer owning out_data
//   busy       registered: a burst is in progress
module fifo_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   sel_q;
  logic [ID_W-1:0]   last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic              start;
  logic              release_gnt;

  // Round-robin scan starting just after the previous winner. Walking the
  // offsets from farthest to nearest lets the nearest set request win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last_q) + i) % NUM_REQ]) begin
        pick     = ID_W'((int'(last_q) + i) % NUM_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Only the granted consumer's request gates the pop; rst kills it in the
  // reset cycle so a word is never lost to a discarded transfer.
  assign r_en = (state_q == BURST) & req[sel_q] & ~r_empty & ~rst;

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    release_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && !r_empty) begin
          state_d = BURST;
          start   = 1'b1;
        end
      end
      BURST: begin
        // Empty while still requested holds the grant indefinitely.
        if ((r_en && cnt_q == CNT_LAST) || !req[sel_q]) begin
          state_d     = IDLE;
          release_gnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      last_q    <= LAST_RST;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      state_q   <= state_d;
      // Delivery stage: word popped this edge appears next cycle.
      out_valid <= r_en;
      if (r_en) begin
        out_data <= r_data;
        out_id   <= sel_q;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (start) begin
        sel_q  <= pick;
        last_q <= pick;
        cnt_q  <= '0;
        gnt    <= NUM_REQ'(1) << pick;
        busy   <= 1'b1;
      end else if (release_gnt) begin
        gnt  <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       r_empty;
  logic [7:0] r_data;
  logic       r_en;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Simple first-word-fall-through FIFO model
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  assign r_empty = (rd_ptr == wr_ptr);
  assign r_data  = mem[rd_ptr];

  always @(posedge clk) if (r_en) rd_ptr <= rd_ptr + 8'd1;

  always #5 clk = ~clk;

  fifo_read_arbiter #(
    .NUM_REQ(4), .BURST_LEN(4), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .r_empty(r_empty), .r_data(r_data),
    .r_en(r_en), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Drive inputs on the falling edge, let combinational outputs settle.
  task automatic apply(input logic rst_v, input logic [3:0] req_v,
                       input int pn, input logic [7:0] pb);
    logic [7:0] d;
    @(negedge clk);
    rst = rst_v;
    req = req_v;
    d = pb;
    for (int k = 0; k < pn; k++) begin
      push(d);
      d = d + 8'd1;
    end
    #1;
    if (r_en) chk("pop_while_empty", {31'd0, r_empty}, 32'd0);
    chk("gnt_onehot", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         pn;
    logic [7:0] pb;
    logic       chk_reg;
    logic       r_en;
    logic [3:0] gnt;
    logic       busy;
    logic       vld;
    logic [7:0] data;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    logic [7:0] rd0;
    logic [7:0] exp_d;

    // rst, req, pushes, base, chk, r_en, gnt, busy, vld, data, id
    // Reset with requests pending and three words queued
    tbl.push_back('{1'b1, 4'hF, 3, 8'h10, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b1, 4'hF, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 0, 8'h00, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 0, 8'h00, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 8'h10, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 0, 8'h00, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 8'h11, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 0, 8'h00, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 8'h12, 2'd0});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 8'h12, 2'd0});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h12, 2'd0});
    // Single consumer 2, six words, burst split 4 + 2 then starved
    tbl.push_back('{1'b0, 4'h4, 6, 8'hA0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h12, 2'd0});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 8'h12, 2'd0});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 8'hA0, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 8'hA1, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 8'hA2, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'hA3, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0, 8'hA3, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 8'hA4, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'h4, 0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 8'hA5, 2'd2});
    // Early release by consumer 1 after two pops; next winner is 3
    tbl.push_back('{1'b0, 4'h6, 3, 8'h30, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'h6, 0, 8'h00, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 8'hA5, 2'd2});
    tbl.push_back('{1'b0, 4'h6, 0, 8'h00, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 8'h30, 2'd1});
    tbl.push_back('{1'b0, 4'h9, 0, 8'h00, 1'b1, 1'b0, 4'h2, 1'b1, 1'b1, 8'h31, 2'd1});
    tbl.push_back('{1'b0, 4'h9, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h31, 2'd1});
    tbl.push_back('{1'b0, 4'h9, 0, 8'h00, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 8'h31, 2'd1});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h8, 1'b1, 1'b1, 8'h32, 2'd3});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h32, 2'd3});
    // Consumer 3: one pop, FIFO empty for 5 cycles, refill, finish burst
    tbl.push_back('{1'b0, 4'h8, 1, 8'h40, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h32, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 0, 8'h00, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 8'h32, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 0, 8'h00, 1'b1, 1'b0, 4'h8, 1'b1, 1'b1, 8'h40, 2'd3});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{1'b0, 4'h8, 0, 8'h00, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 8'h40, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 4, 8'h41, 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 8'h40, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 0, 8'h00, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 8'h41, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 0, 8'h00, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 8'h42, 2'd3});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'h43, 2'd3});
    tbl.push_back('{1'b0, 4'h0, 0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h43, 2'd3});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].pn, tbl[i].pb);
      chk($sformatf("row%0d.r_en", i), {31'd0, r_en}, {31'd0, tbl[i].r_en});
      if (tbl[i].chk_reg) begin
        chk($sformatf("row%0d.gnt", i),       {28'd0, gnt},       {28'd0, tbl[i].gnt});
        chk($sformatf("row%0d.busy", i),      {31'd0, busy},      {31'd0, tbl[i].busy});
        chk($sformatf("row%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
        chk($sformatf("row%0d.out_data", i),  {24'd0, out_data},  {24'd0, tbl[i].data});
        chk($sformatf("row%0d.out_id", i),    {30'd0, out_id},    {30'd0, tbl[i].id});
      end
    end

    // Round-robin with all requesting and a never-empty FIFO (0x44 is left
    // over from the previous burst): grants 0,1,2,3,0, four words each.
    n = 0;
    for (int t = 0; t <= 25; t++) begin
      apply(1'b0, (t < 25) ? 4'hF : 4'h0, (t == 0) ? 48 : 0, 8'h50);
      chk($sformatf("rr%0d.gnt", t), {28'd0, gnt},
          (t % 5 == 0) ? 32'd0 : (32'd1 << ((t / 5) % 4)));
      chk($sformatf("rr%0d.r_en", t), {31'd0, r_en}, (t % 5 != 0) ? 32'd1 : 32'd0);
      if (out_valid) begin
        exp_d = (n == 0) ? 8'h44 : 8'h50 + 8'(n - 1);
        chk($sformatf("rr_word%0d.id", n),   {30'd0, out_id},   32'((n / 4) % 4));
        chk($sformatf("rr_word%0d.data", n), {24'd0, out_data}, {24'd0, exp_d});
        n++;
      end
    end
    chk("rr_word_count", 32'(n), 32'd20);

    // Reset asserted during the third pop of consumer 0's burst
    apply(1'b0, 4'h1, 0, 8'h00);
    rd0 = rd_ptr;
    chk("rmb.idle_gnt", {28'd0, gnt}, 32'd0);
    apply(1'b0, 4'h1, 0, 8'h00);
    chk("rmb.gnt", {28'd0, gnt}, 32'h1);
    chk("rmb.pop1", {31'd0, r_en}, 32'd1);
    apply(1'b0, 4'h1, 0, 8'h00);
    chk("rmb.pop2", {31'd0, r_en}, 32'd1);
    chk("rmb.word1", {24'd0, out_data}, 32'h63);
    apply(1'b1, 4'h1, 0, 8'h00);
    chk("rmb.r_en_in_rst", {31'd0, r_en}, 32'd0);
    chk("rmb.word2", {24'd0, out_data}, 32'h64);
    apply(1'b0, 4'h1, 0, 8'h00);
    chk("rmb.gnt_after", {28'd0, gnt}, 32'd0);
    chk("rmb.busy_after", {31'd0, busy}, 32'd0);
    chk("rmb.valid_after", {31'd0, out_valid}, 32'd0);
    chk("rmb.data_after", {24'd0, out_data}, 32'd0);
    chk("rmb.r_en_after", {31'd0, r_en}, 32'd0);
    chk("rmb.pop_count", {24'd0, 8'(rd_ptr - rd0)}, 32'd2);
    apply(1'b0, 4'h1, 0, 8'h00);
    chk("rmb.regrant0", {28'd0, gnt}, 32'h1);
    chk("rmb.regrant_pop", {31'd0, r_en}, 32'd1);
    apply(1'b0, 4'h0, 0, 8'h00);
    apply(1'b0, 4'h0, 0, 8'h00);
    chk("rmb.resumed_word", {24'd0, out_data}, 32'h65);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
